ni_tester_mc: RTL and testbench

Multi-channel traffic generator and checker for network-interface FIFOs. It drives CHANNELS independent valid/ready write streams into the device under test and reads back the same number of words per channel. Each received word is compared against an internal reference generator running the same pattern. It reports per-channel error counts, a timeout flag and an overall pass flag. This block supersedes the single-channel ni_tester as the self-test engine in front of FIFO/NI instances.

---
 rtl/ni_tester_mc.sv | 198 +++++++++++++++++++
 tb/tb_ni_tester_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tester_mc.sv
// Multi-channel traffic generator/checker for NI FIFOs: drives CHANNELS write streams,
// reads the same words back, compares against a reference pattern and reports pass/fail.
module ni_tester_mc #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CHANNELS   = 2,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] POLY       = 8'h1D,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic [DATA_WIDTH-1:0]            seed,
  input  logic [CNT_WIDTH-1:0]             burst_len,
  input  logic                             throttle,
  output logic [CHANNELS-1:0]              tx_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]   tx_data,
  input  logic [CHANNELS-1:0]              tx_ready,
  input  logic [CHANNELS-1:0]              rx_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   rx_data,
  output logic [CHANNELS-1:0]              rx_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             timeout,
  output logic [CHANNELS*CNT_WIDTH-1:0]    err_cnt
);

  localparam int         WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First word of a channel's pattern; WALK1 keeps its state as the one-hot word itself.
  function automatic logic [DATA_WIDTH-1:0] gen_init(input logic [1:0] md,
                                                     input logic [DATA_WIDTH-1:0] sd);
    logic [DATA_WIDTH-1:0] one_v;
    one_v = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    case (md)
      MODE_LFSR: gen_init = (sd == '0) ? one_v : sd;
      MODE_WALK: gen_init = one_v << (32'(sd) % DATA_WIDTH);
      default:   gen_init = sd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [1:0] md,
                                                     input logic [DATA_WIDTH-1:0] cur);
    case (md)
      MODE_LFSR: gen_next = {cur[DATA_WIDTH-2:0], 1'b0} ^ (cur[DATA_WIDTH-1] ? POLY : '0);
      MODE_WALK: gen_next = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
      default:   gen_next = cur + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endcase
  endfunction

  state_t                 state_r, state_n_s;
  logic [1:0]             mode_r;
  logic [CNT_WIDTH-1:0]   bl_r;
  logic                   throttle_r;
  logic [1:0]             phase_r, phase_n_s;
  logic [WD_W-1:0]        wd_r, wd_n_s;
  logic                   first_r;
  logic [CNT_WIDTH-1:0]   tx_cnt_r [CHANNELS];
  logic [CNT_WIDTH-1:0]   rx_cnt_r [CHANNELS];
  logic [CNT_WIDTH-1:0]   err_r    [CHANNELS];
  logic [DATA_WIDTH-1:0]  tx_gen_r [CHANNELS];
  logic [DATA_WIDTH-1:0]  rx_gen_r [CHANNELS];
  logic [CHANNELS-1:0]    tx_valid_r, rx_ready_r;
  logic                   busy_r, done_r, pass_r, timeout_r;

  logic                   start_s, all_done_s, errs_zero_s, any_hs_s, wd_exp_s;
  logic [CHANNELS-1:0]    hs_tx_s, hs_rx_s;
  logic [CNT_WIDTH-1:0]   tx_cnt_n_s [CHANNELS];
  logic [CNT_WIDTH-1:0]   rx_cnt_n_s [CHANNELS];
  logic [CNT_WIDTH-1:0]   err_n_s    [CHANNELS];

  // Handshakes, next-state counters, watchdog and FSM next state.
  always_comb begin
    start_s     = start && (state_r != ST_RUN);
    all_done_s  = 1'b1;
    errs_zero_s = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      hs_tx_s[c]    = tx_valid_r[c] & tx_ready[c];
      hs_rx_s[c]    = rx_valid[c] & rx_ready_r[c];
      tx_cnt_n_s[c] = tx_cnt_r[c] + CNT_WIDTH'(hs_tx_s[c]);
      rx_cnt_n_s[c] = rx_cnt_r[c] + CNT_WIDTH'(hs_rx_s[c]);
      if (hs_rx_s[c] && (rx_data[c*DATA_WIDTH +: DATA_WIDTH] != rx_gen_r[c]) &&
          (err_r[c] != '1)) begin
        err_n_s[c] = err_r[c] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        err_n_s[c] = err_r[c];
      end
      all_done_s  = all_done_s & (tx_cnt_n_s[c] == bl_r) & (rx_cnt_n_s[c] == bl_r);
      errs_zero_s = errs_zero_s & (err_n_s[c] == '0);
    end
    any_hs_s  = (|hs_tx_s) | (|hs_rx_s);
    // The arming cycle counts as activity so an idle run aborts TIMEOUT+1 cycles after it.
    wd_n_s    = (first_r || any_hs_s) ? '0 : wd_r + {{(WD_W-1){1'b0}}, 1'b1};
    wd_exp_s  = (wd_n_s == WD_W'(TIMEOUT));
    phase_n_s = start_s ? 2'd0 : phase_r + 2'd1;
    case (state_r)
      ST_IDLE: state_n_s = start_s ? ST_RUN : ST_IDLE;
      ST_RUN:  state_n_s = (all_done_s || wd_exp_s) ? ST_DONE : ST_RUN;
      ST_DONE: state_n_s = start_s ? ST_RUN : ST_DONE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State register, counters, generators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'd0;
      bl_r       <= '0;
      throttle_r <= 1'b0;
      phase_r    <= 2'd0;
      wd_r       <= '0;
      first_r    <= 1'b0;
      tx_valid_r <= '0;
      rx_ready_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        tx_cnt_r[c] <= '0;
        rx_cnt_r[c] <= '0;
        err_r[c]    <= '0;
        tx_gen_r[c] <= '0;
        rx_gen_r[c] <= '0;
      end
    end else begin
      state_r <= state_n_s;
      phase_r <= phase_n_s;
      if (start_s) begin
        mode_r     <= mode;
        bl_r       <= burst_len;
        throttle_r <= throttle;
        wd_r       <= '0;
        first_r    <= 1'b1;
        busy_r     <= 1'b1;
        done_r     <= 1'b0;
        pass_r     <= 1'b0;
        timeout_r  <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          tx_cnt_r[c]   <= '0;
          rx_cnt_r[c]   <= '0;
          err_r[c]      <= '0;
          tx_gen_r[c]   <= gen_init(mode, seed ^ DATA_WIDTH'(c));
          rx_gen_r[c]   <= gen_init(mode, seed ^ DATA_WIDTH'(c));
          tx_valid_r[c] <= (burst_len != '0);
          rx_ready_r[c] <= (burst_len != '0);
        end
      end else if (state_r == ST_RUN) begin
        wd_r    <= wd_n_s;
        first_r <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          tx_cnt_r[c] <= tx_cnt_n_s[c];
          rx_cnt_r[c] <= rx_cnt_n_s[c];
          err_r[c]    <= err_n_s[c];
          if (hs_tx_s[c]) tx_gen_r[c] <= gen_next(mode_r, tx_gen_r[c]);
          if (hs_rx_s[c]) rx_gen_r[c] <= gen_next(mode_r, rx_gen_r[c]);
        end
        if (state_n_s == ST_DONE) begin
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          timeout_r  <= !all_done_s;
          pass_r     <= all_done_s && errs_zero_s;
          tx_valid_r <= '0;
          rx_ready_r <= '0;
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            tx_valid_r[c] <= (tx_cnt_n_s[c] < bl_r);
            rx_ready_r[c] <= (rx_cnt_n_s[c] < bl_r) && !(throttle_r && (phase_n_s == 2'd3));
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign tx_data[g*DATA_WIDTH +: DATA_WIDTH] = tx_gen_r[g];
    assign err_cnt[g*CNT_WIDTH +: CNT_WIDTH]   = err_r[g];
  end

  assign tx_valid = tx_valid_r;
  assign rx_ready = rx_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_ni_tester_mc.sv
// Bench for ni_tester_mc: FIFO loopback environment, behavioural pattern model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ni_tester_mc;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  seed = 8'h00;
  logic [15:0] burst_len = 16'd0;
  logic        throttle = 1'b0;
  logic [1:0]  tx_valid, rx_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_ready = 2'b00;
  logic [1:0]  rx_valid = 2'b00;
  logic [15:0] rx_data = 16'h0000;
  logic        busy, done, pass, timeout;
  logic [31:0] err_cnt;

  ni_tester_mc #(.DATA_WIDTH(8), .CHANNELS(2), .CNT_WIDTH(16), .POLY(8'h1D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .burst_len(burst_len),
    .throttle(throttle), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // environment controls
  int   policy = 0;     // 0: tx_ready=1, 1: random, 2: tx_ready=0
  logic corrupt = 1'b0; // flip bit 0 of ch1 word 8'h14
  logic [7:0] fifo [2][$];
  logic [1:0] push_q = 2'b00, pop_q = 2'b00;
  logic [7:0] push_w [2];

  // Loopback FIFO per channel, one-cycle latency, inputs driven 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int c = 0; c < 2; c++) fifo[c].delete();
      rx_valid = 2'b00;
      rx_data  = 16'h0000;
      tx_ready = 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic [7:0] w;
        if (pop_q[c] && fifo[c].size() > 0) void'(fifo[c].pop_front());
        if (push_q[c]) fifo[c].push_back(push_w[c]);
        rx_valid[c] = (fifo[c].size() > 0);
        w = (fifo[c].size() > 0) ? fifo[c][0] : 8'h00;
        if (corrupt && c == 1 && w == 8'h14) w = w ^ 8'h01;
        rx_data[c*8 +: 8] = w;
        case (policy)
          0:       tx_ready[c] = 1'b1;
          1:       tx_ready[c] = ($urandom_range(0, 3) != 0);
          default: tx_ready[c] = 1'b0;
        endcase
      end
    end
  end

  // Behavioural model: expected word lists built from the pattern formulas at start.
  int         m_state = 0; // 0 idle, 1 run, 2 done
  int         m_tx [2], m_rx [2], m_err [2];
  int         m_bl, m_wd, m_runcyc;
  bit         m_thr, m_first, m_to, m_pass;
  logic [7:0] exp_w [2][256];

  function automatic bit m_rdy(int c);
    return (m_state == 1) && (m_rx[c] < m_bl) && !(m_thr && (m_runcyc % 4 == 3));
  endfunction

  // Compare process: checks outputs on each falling edge, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      m_state = 0; m_to = 0; m_pass = 0;
      for (int c = 0; c < 2; c++) begin m_tx[c] = 0; m_rx[c] = 0; m_err[c] = 0; end
      push_q = 2'b00; pop_q = 2'b00;
    end else begin
      int  st0;
      bit  any, fin, ez;
      st0 = m_state;
      check("busy", busy, m_state == 1);
      check("done", done, m_state == 2);
      check("timeout", timeout, m_to);
      check("pass", pass, (m_state == 2) && m_pass);
      if (m_state == 0) check("idle_tx_data", tx_data, 16'h0000);
      for (int c = 0; c < 2; c++) begin
        bit tv;
        tv = (m_state == 1) && (m_tx[c] < m_bl);
        check("tx_valid", tx_valid[c], tv);
        check("rx_ready", rx_ready[c], m_rdy(c));
        check("err_cnt", err_cnt[c*16 +: 16], m_err[c]);
        if (tv) check("tx_data", tx_data[c*8 +: 8], exp_w[c][m_tx[c]]);
        push_q[c] = tx_valid[c] & tx_ready[c];
        push_w[c] = tx_data[c*8 +: 8];
        pop_q[c]  = rx_valid[c] & rx_ready[c];
      end
      if (st0 == 1) begin
        any = 0; fin = 1; ez = 1;
        for (int c = 0; c < 2; c++) begin
          if (rx_valid[c] && m_rdy(c)) begin
            if (rx_data[c*8 +: 8] != exp_w[c][m_rx[c]] && m_err[c] < 65535) m_err[c]++;
            m_rx[c]++;
            any = 1;
          end
          if (m_tx[c] < m_bl && tx_ready[c]) begin m_tx[c]++; any = 1; end
          fin = fin && (m_tx[c] == m_bl) && (m_rx[c] == m_bl);
          ez  = ez && (m_err[c] == 0);
        end
        m_wd = (m_first || any) ? 0 : m_wd + 1;
        m_first = 0;
        m_runcyc++;
        if (fin) begin m_state = 2; m_pass = ez; end
        else if (m_wd == TMO) begin m_state = 2; m_to = 1; m_pass = 0; end
      end else if (start) begin
        m_state = 1; m_bl = burst_len; m_thr = throttle; m_wd = 0; m_first = 1;
        m_runcyc = 0; m_to = 0; m_pass = 0;
        for (int c = 0; c < 2; c++) begin
          logic [7:0] sc, lf;
          m_tx[c] = 0; m_rx[c] = 0; m_err[c] = 0;
          sc = seed ^ 8'(c);
          lf = (sc == 8'h00) ? 8'h01 : sc;
          for (int k = 0; k < 256; k++) begin
            case (mode)
              2'd1: begin
                exp_w[c][k] = lf;
                lf = {lf[6:0], 1'b0} ^ (lf[7] ? 8'h1D : 8'h00);
              end
              2'd2:    exp_w[c][k] = 8'h01 << ((int'(sc) + k) % 8);
              default: exp_w[c][k] = sc + 8'(k);
            endcase
          end
        end
      end
    end
  end

  task automatic start_run(input logic [1:0] md, input logic [7:0] sd, input logic [15:0] bl,
                           input logic thr, input int pol, output logic [15:0] fw);
    policy = pol; mode = md; seed = sd; burst_len = bl; throttle = thr;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fw = tx_data;
  endtask

  // n counts cycles after the start edge: n=1 is the first RUN cycle.
  task automatic wait_done(input int poke, output int cyc);
    int n;
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      start = (n == poke);
      if (n == poke) seed = ~seed;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
    cyc = n;
  endtask

  initial begin
    logic [15:0] fw;
    int cyc, k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 2'b00);
    check("rst_rx_ready", rx_ready, 2'b00);
    check("rst_flags", {busy, done, pass, timeout}, 4'b0000);
    check("rst_err", err_cnt, 32'h0);
    check("rst_tx_data", tx_data, 16'h0000);
    rst = 1'b0;

    // INCR loopback
    start_run(2'd0, 8'h10, 16'd16, 1'b0, 0, fw);
    check("incr_first_word", fw, 16'h1110);
    check("incr_first_valid", tx_valid, 2'b11);
    wait_done(-1, cyc);
    check("incr_cycles", cyc, 18);
    check("incr_pass", pass, 1'b1);
    check("incr_err", err_cnt, 32'h0);

    // corrupted ch1 word 3
    corrupt = 1'b1;
    start_run(2'd0, 8'h10, 16'd16, 1'b0, 0, fw);
    wait_done(-1, cyc);
    corrupt = 1'b0;
    check("corrupt_cycles", cyc, 18);
    check("corrupt_err", err_cnt, 32'h0001_0000);
    check("corrupt_pass", pass, 1'b0);

    // zero-length burst from DONE clears err_cnt
    start_run(2'd0, 8'h33, 16'd0, 1'b0, 0, fw);
    check("zero_tx_valid", tx_valid, 2'b00);
    wait_done(-1, cyc);
    check("zero_cycles", cyc, 2);
    check("zero_err", err_cnt, 32'h0);
    check("zero_pass", pass, 1'b1);

    // LFSR, throttled, random tx stalls, ignored start mid-run
    start_run(2'd1, 8'h01, 16'd100, 1'b1, 1, fw);
    check("lfsr_first_word", fw, 16'h0101);
    check("lfsr_model_w8", exp_w[0][8], 8'h1D);
    wait_done(20, cyc);
    check("lfsr_pass", pass, 1'b1);
    check("lfsr_err", err_cnt, 32'h0);

    // WALK1
    start_run(2'd2, 8'h06, 16'd10, 1'b0, 1, fw);
    check("walk_first_word", fw, 16'h8040);
    wait_done(-1, cyc);
    check("walk_pass", pass, 1'b1);

    // mode 3 behaves as INCR, with wrap
    start_run(2'd3, 8'hFE, 16'd5, 1'b0, 0, fw);
    check("m3_first_word", fw, 16'hFFFE);
    wait_done(-1, cyc);
    check("m3_pass", pass, 1'b1);

    // watchdog
    start_run(2'd0, 8'h10, 16'd16, 1'b0, 2, fw);
    wait_done(-1, cyc);
    check("wd_cycles", cyc, 66);
    check("wd_timeout", timeout, 1'b1);
    check("wd_pass", pass, 1'b0);

    // reset mid-burst, then a clean run
    start_run(2'd0, 8'h10, 16'd16, 1'b0, 0, fw);
    k = 0;
    while (tx_data[7:0] != 8'h17 && k < 40) begin @(posedge clk); #1; k++; end
    check("mid_word7_reached", tx_data[7:0], 8'h17);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", tx_valid, 2'b00);
    check("mid_rst_rx_ready", rx_ready, 2'b00);
    check("mid_rst_flags", {busy, done, pass, timeout}, 4'b0000);
    check("mid_rst_err", err_cnt, 32'h0);
    check("mid_rst_tx_data", tx_data, 16'h0000);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    start_run(2'd0, 8'h10, 16'd16, 1'b0, 0, fw);
    wait_done(-1, cyc);
    check("post_rst_cycles", cyc, 18);
    check("post_rst_pass", pass, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
